// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the RGB LED push-button controller.
//   mode_t          colour mode encoding driven on the o_mode status port
//   MODE_W/LEVEL_W  widths of the mode and brightness-level fields
//   duty_for_level  PWM compare value for a brightness level (1/8, 1/4, 1/2, full)
package led_ctrl_pkg;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned LEVEL_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ModeOff     = 3'd0,
    ModeRed     = 3'd1,
    ModeGreen   = 3'd2,
    ModeBlue    = 3'd3,
    ModeWhite   = 3'd4,
    ModeBreathe = 3'd5
  } mode_t;

  // Level 0..3 maps to 2**(pwm_bits-3+level); level 3 equals the full period.
  function automatic int unsigned duty_for_level(input logic [LEVEL_W-1:0] level,
                                                 input int unsigned       pwm_bits);
    return 32'd1 << (pwm_bits - 32'd3 + 32'(level));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, debouncer and press-pulse generator.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous reset, active-high
//   i_btn    raw asynchronous button level
//   o_press  one-cycle pulse on an accepted 0->1 transition of the debounced level
// The debounced level changes only after the synchronised input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; releases produce no pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_state;
  logic            r_press;
  logic [CntW-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_sync2 != r_state);
  // The cycle that completes the stable window flips the debounced level.
  assign w_accept  = w_differs && (r_cnt == CntLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= w_accept && r_sync2;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_state <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CntOne;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/rgb_led_btn_ctrl.sv
// RGB LED controller driven by two board push-buttons.
//   btn0 steps the colour mode OFF->RED->GREEN->BLUE->WHITE->OFF, btn1 steps a 4-step
//   brightness level (wraps 3->0). All three channels share one free-running PWM counter.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous reset, active-high
//   i_btn0    raw button, advance colour mode
//   i_btn1    raw button, advance brightness level
//   o_led0_r  red PWM output, active-high
//   o_led0_g  green PWM output, active-high
//   o_led0_b  blue PWM output, active-high
//   o_mode    current colour mode encoding
// Build option: define RGB_BREATHE_EN to add a BREATHE mode (blue triangle ramp) between
// WHITE and OFF.
module rgb_led_btn_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned PWM_BITS            = 8,
  parameter int unsigned BREATHE_STEP_CYCLES = 390_625
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btn0,
  input  logic              i_btn1,
  output logic              o_led0_r,
  output logic              o_led0_g,
  output logic              o_led0_b,
  output logic [MODE_W-1:0] o_mode
);

  localparam int unsigned DutyW = PWM_BITS + 1;

  logic w_press0;
  logic w_press1;

  mode_t               r_mode;
  mode_t               w_mode_next;
  logic [LEVEL_W-1:0]  r_level;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_led_r;
  logic                r_led_g;
  logic                r_led_b;

  logic             w_en_r;
  logic             w_en_g;
  logic             w_en_b;
  logic [DutyW-1:0] w_duty;
  logic [DutyW-1:0] w_duty_b;
  logic [DutyW-1:0] w_pwm_ext;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_btn0),
    .o_press(w_press0)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_btn1),
    .o_press(w_press1)
  );

  // Mode FSM: state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= ModeOff;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Mode FSM: next state.
  always_comb begin
    w_mode_next = r_mode;
    if (w_press0) begin
      unique case (r_mode)
        ModeOff:     w_mode_next = ModeRed;
        ModeRed:     w_mode_next = ModeGreen;
        ModeGreen:   w_mode_next = ModeBlue;
        ModeBlue:    w_mode_next = ModeWhite;
`ifdef RGB_BREATHE_EN
        ModeWhite:   w_mode_next = ModeBreathe;
`else
        ModeWhite:   w_mode_next = ModeOff;
`endif
        ModeBreathe: w_mode_next = ModeOff;
        default:     w_mode_next = ModeOff;
      endcase
    end
  end

  // Mode FSM: channel enables.
  always_comb begin
    w_en_r = 1'b0;
    w_en_g = 1'b0;
    w_en_b = 1'b0;
    unique case (r_mode)
      ModeRed:     w_en_r = 1'b1;
      ModeGreen:   w_en_g = 1'b1;
      ModeBlue:    w_en_b = 1'b1;
      ModeWhite: begin
        w_en_r = 1'b1;
        w_en_g = 1'b1;
        w_en_b = 1'b1;
      end
      ModeBreathe: w_en_b = 1'b1;
      default:     ;
    endcase
  end

  assign w_duty    = DutyW'(duty_for_level(r_level, PWM_BITS));
  assign w_pwm_ext = {1'b0, r_pwm_cnt};

`ifdef RGB_BREATHE_EN
  localparam int unsigned StepW = (BREATHE_STEP_CYCLES > 1) ? $clog2(BREATHE_STEP_CYCLES) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(BREATHE_STEP_CYCLES - 1);
  localparam logic [StepW-1:0] StepOne  = StepW'(1);
  localparam logic [DutyW-1:0] DutyOne  = DutyW'(1);
  localparam logic [DutyW-1:0] DutyTop  = DutyW'(32'd1 << PWM_BITS);

  logic [DutyW-1:0] r_br_duty;
  logic             r_br_up;
  logic [StepW-1:0] r_br_step;
  logic             w_br_enter;

  // Every entry into BREATHE restarts the ramp from zero, rising.
  assign w_br_enter = (w_mode_next == ModeBreathe) && (r_mode != ModeBreathe);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_br_enter) begin
      r_br_duty <= '0;
      r_br_up   <= 1'b1;
      r_br_step <= '0;
    end else if (r_mode == ModeBreathe) begin
      if (r_br_step == StepLast) begin
        r_br_step <= '0;
        if (r_br_up) begin
          r_br_duty <= r_br_duty + DutyOne;
          if (r_br_duty == DutyTop - DutyOne) r_br_up <= 1'b0;
        end else begin
          r_br_duty <= r_br_duty - DutyOne;
          if (r_br_duty == DutyOne) r_br_up <= 1'b1;
        end
      end else begin
        r_br_step <= r_br_step + StepOne;
      end
    end
  end

  // Brightness level does not apply to the breathe ramp.
  assign w_duty_b = (r_mode == ModeBreathe) ? r_br_duty : w_duty;
`else
  logic w_unused_step;
  assign w_unused_step = ^BREATHE_STEP_CYCLES;
  assign w_duty_b      = w_duty;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level   <= 2'd3;
      r_pwm_cnt <= '0;
      r_led_r   <= 1'b0;
      r_led_g   <= 1'b0;
      r_led_b   <= 1'b0;
    end else begin
      if (w_press1) r_level <= r_level + 2'd1;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      // Mode/level changes apply immediately, even mid-period.
      r_led_r   <= w_en_r && (w_pwm_ext < w_duty);
      r_led_g   <= w_en_g && (w_pwm_ext < w_duty);
      r_led_b   <= w_en_b && (w_pwm_ext < w_duty_b);
    end
  end

  assign o_led0_r = r_led_r;
  assign o_led0_g = r_led_g;
  assign o_led0_b = r_led_b;
  assign o_mode   = r_mode;

endmodule

// File: tb/tb_rgb_led_btn_ctrl.sv
// Self-checking bench for rgb_led_btn_ctrl (DEBOUNCE_CYCLES=4, PWM_BITS=4, BREATHE_STEP_CYCLES=2).
module tb_rgb_led_btn_ctrl;

  localparam int unsigned D      = 4;
  localparam int unsigned PB     = 4;
  localparam int unsigned STEP   = 2;
  localparam int          PERIOD = 16;
`ifdef RGB_BREATHE_EN
  localparam int NMODES = 6;
`else
  localparam int NMODES = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b0  = 1'b0;
  logic       b1  = 1'b0;
  logic       lr, lg, lb;
  logic [2:0] mode;

  always #5 clk = ~clk;

  rgb_led_btn_ctrl #(
    .DEBOUNCE_CYCLES    (D),
    .PWM_BITS           (PB),
    .BREATHE_STEP_CYCLES(STEP)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_btn0  (b0),
    .i_btn1  (b1),
    .o_led0_r(lr),
    .o_led0_g(lg),
    .o_led0_b(lb),
    .o_mode  (mode)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Raw button value seen at each clock edge since reset release; the debouncer works on the
  // value sampled two edges earlier and accepts a change once the last D such samples all
  // disagree with the current debounced level.
  bit hist[2][0:4095];
  int m_n;
  bit m_deb[2];
  bit m_pend[2];
  int m_mode;
  int m_level;
  int m_br_entry;
  bit m_r, m_g, m_b;

  function automatic bit synced_at(input int btn, input int e);
    return (e >= 3) ? hist[btn][(e - 3) % 4096] : 1'b0;
  endfunction

  task automatic model_edge(input bit r, input bit x0, input bit x1);
    int pwm, duty, t, bd;
    bit all;
    if (r) begin
      m_n = 0; m_deb = '{0, 0}; m_pend = '{0, 0};
      m_mode = 0; m_level = 3; m_r = 0; m_g = 0; m_b = 0;
      return;
    end
    m_n++;
    pwm  = (m_n - 1) % PERIOD;
    duty = PERIOD * (1 << m_level) / 8;
    m_r = (m_mode == 1 || m_mode == 4) && (pwm < duty);
    m_g = (m_mode == 2 || m_mode == 4) && (pwm < duty);
    m_b = (m_mode == 3 || m_mode == 4) && (pwm < duty);
    if (m_mode == 5) begin
      t  = ((m_n - 1 - m_br_entry) / STEP) % (2 * PERIOD);
      bd = (t <= PERIOD) ? t : 2 * PERIOD - t;
      m_b = (pwm < bd);
    end
    if (m_pend[0]) begin
      m_mode = (m_mode + 1) % NMODES;
      if (m_mode == 5) m_br_entry = m_n;
    end
    if (m_pend[1]) m_level = (m_level + 1) % 4;
    hist[0][(m_n - 1) % 4096] = x0;
    hist[1][(m_n - 1) % 4096] = x1;
    for (int b = 0; b < 2; b++) begin
      all = 1'b1;
      for (int k = 0; k < int'(D); k++) begin
        if (synced_at(b, m_n - k) == m_deb[b]) all = 1'b0;
      end
      m_pend[b] = 1'b0;
      if (all) begin
        m_deb[b]  = !m_deb[b];
        m_pend[b] = m_deb[b];
      end
    end
  endtask

  // One clock: drive inputs, advance the model over the edge, compare just after it.
  task automatic tick(input bit x0, input bit x1, input bit r = 1'b0);
    b0 = x0; b1 = x1; rst = r;
    @(posedge clk);
    model_edge(r, x0, x1);
    #1;
    check("model_mode", int'(mode), m_mode);
    check("model_led_r", int'(lr), int'(m_r));
    check("model_led_g", int'(lg), int'(m_g));
    check("model_led_b", int'(lb), int'(m_b));
  endtask

  task automatic do_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);
  endtask

  task automatic press(input int btn);
    repeat (8) tick(btn == 0, btn == 1);
    repeat (8) tick(0, 0);
  endtask

  task automatic count16(output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    repeat (PERIOD) begin
      tick(0, 0);
      cr += int'(lr); cg += int'(lg); cb += int'(lb);
    end
  endtask

  typedef struct {
    int n0;
    int n1;
    int exp_mode;
    int exp_r;
    int exp_g;
    int exp_b;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cr, cg, cb, changes, x0, x1, hold0, hold1;
    bit r;

    // Presses from reset (level starts at 3) -> mode and high cycles per 16-cycle period.
    vecs[0] = '{0, 0, 0,  0,  0,  0};
    vecs[1] = '{1, 0, 1, 16,  0,  0};
    vecs[2] = '{1, 1, 1,  2,  0,  0};
    vecs[3] = '{1, 2, 1,  4,  0,  0};
    vecs[4] = '{1, 3, 1,  8,  0,  0};
    vecs[5] = '{1, 4, 1, 16,  0,  0};
    vecs[6] = '{2, 0, 2,  0, 16,  0};
    vecs[7] = '{3, 2, 3,  0,  0,  4};
    vecs[8] = '{4, 3, 4,  8,  8,  8};
    vecs[9] = '{0, 2, 0,  0,  0,  0};

    // Reset state and idle.
    do_reset();
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0);
      if (mode != 3'd0 || lr || lg || lb) changes++;
    end
    check("t1_idle_nonzero", changes, 0);

    // Glitchy btn0 then held: one advance, 7 cycles after the final rising edge.
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2) == 0, 0);
    for (int k = 1; k <= 7; k++) begin
      tick(1, 0);
      if (k == 6) check("t2_mode_before", int'(mode), 0);
      if (k == 7) check("t2_mode_after", int'(mode), 1);
    end
    changes = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1, 0);
      if (mode != 3'd1) changes++;
    end
    check("t2_held_changes", changes, 0);
    repeat (8) tick(0, 0);

    // Table-driven presses.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      for (int p = 0; p < vecs[i].n0; p++) press(0);
      for (int p = 0; p < vecs[i].n1; p++) press(1);
      count16(cr, cg, cb);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
      check($sformatf("vec%0d_r", i), cr, vecs[i].exp_r);
      check($sformatf("vec%0d_g", i), cg, vecs[i].exp_g);
      check($sformatf("vec%0d_b", i), cb, vecs[i].exp_b);
    end

    // Mode cycle: red active only in RED and WHITE.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      press(0);
      count16(cr, cg, cb);
      check($sformatf("t3_mode%0d", k), int'(mode), (k + 1) % NMODES);
      check($sformatf("t3_red%0d", k), cr, (((k + 1) % NMODES) == 1 || k == 3) ? 16 : 0);
    end

    // Level sweep in RED.
    do_reset();
    press(0);
    press(1);
    count16(cr, cg, cb);
    check("t4_level0", cr, 2);
    repeat (3) press(1);
    count16(cr, cg, cb);
    check("t4_level3", cr, 16);
    press(1);
    count16(cr, cg, cb);
    check("t4_wrap", cr, 2);

    // Simultaneous presses advance mode and level together.
    do_reset();
    press(0);
    for (int k = 1; k <= 7; k++) begin
      tick(1, 1);
      if (k == 6) check("t5_mode_before", int'(mode), 1);
      if (k == 7) check("t5_mode_after", int'(mode), 2);
    end
    repeat (8) tick(0, 0);
    count16(cr, cg, cb);
    check("t5_green_level0", cg, 2);
    check("t5_red_off", cr, 0);

    // Reset in the middle of a debounce window.
    do_reset();
    repeat (5) tick(1, 0);
    tick(1, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      tick(1, 0);
      if (k == 6) check("t6_mode_before", int'(mode), 0);
      if (k == 7) check("t6_mode_after", int'(mode), 1);
    end
    repeat (8) tick(0, 0);

`ifdef RGB_BREATHE_EN
    do_reset();
    repeat (5) press(0);
    check("t6_breathe_mode", int'(mode), 5);
    changes = 0;
    for (int i = 0; i < 64; i++) begin
      tick(0, 0);
      if (lr || lg) changes++;
    end
    check("t6_breathe_rg", changes, 0);
`endif

    // Randomised buttons with occasional reset, checked against the model every cycle.
    do_reset();
    x0 = 0; x1 = 0; hold0 = 0; hold1 = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold0 == 0) begin x0 = $urandom_range(0, 1); hold0 = $urandom_range(1, 14); end
      if (hold1 == 0) begin x1 = $urandom_range(0, 1); hold1 = $urandom_range(1, 14); end
      hold0--;
      hold1--;
      r = ($urandom_range(0, 399) == 0);
      tick(x0[0], x1[0], r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
